// File: rtl/sim_ram_pkg.sv
// Shared types, limits and helpers for the behavioural simulation RAM.
// be_merge works on the widest supported word; callers zero-extend and truncate.
package sim_ram_pkg;

    typedef enum logic {
        RDW_READ_FIRST,
        RDW_WRITE_FIRST
    } rdw_mode_e;

    localparam int unsigned MAX_RD_LATENCY = 4;
    localparam int unsigned MAX_DATA_SIZE  = 32;

    typedef logic [8*MAX_DATA_SIZE-1:0] word_max_t;
    typedef logic [MAX_DATA_SIZE-1:0]   be_max_t;

    function automatic word_max_t be_merge(word_max_t old_w, word_max_t new_w, be_max_t be);
        word_max_t res;
        for (int i = 0; i < int'(MAX_DATA_SIZE); i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/sim_ram_rd_pipe.sv
// Valid+data delay line with asynchronous reset. Data stages only load behind a
// valid entry, so the output data holds the last valid word through bubbles.
module sim_ram_rd_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    logic [DEPTH-1:0] valid_q;
    logic [WIDTH-1:0] data_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= valid_i;
            if (valid_i) begin
                data_q[0] <= data_i;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign valid_o = valid_q[DEPTH-1];
    assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/sim_ram_pipe.sv
// Behavioural simulation RAM: byte-enabled write port, pipelined read port with
// selectable read-during-write policy and a registered collision pulse.
module sim_ram_pipe
    import sim_ram_pkg::*;
#(
    parameter int unsigned DATA_SIZE  = 4,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned RD_LATENCY = 1,
    parameter rdw_mode_e   RDW_MODE   = RDW_READ_FIRST,
    localparam int unsigned DATA_WIDTH = 8 * DATA_SIZE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_SIZE-1:0]  wr_be,
    output logic                  collision
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;

    if (RD_LATENCY < 1 || RD_LATENCY > MAX_RD_LATENCY) begin : g_bad_latency
        $error("sim_ram_pipe: RD_LATENCY must be in 1..%0d", MAX_RD_LATENCY);
    end
    if (DATA_SIZE < 1 || DATA_SIZE > MAX_DATA_SIZE) begin : g_bad_size
        $error("sim_ram_pipe: DATA_SIZE must be in 1..%0d", MAX_DATA_SIZE);
    end

    logic [DATA_WIDTH-1:0] mem_q [Depth];
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  collision_d;
    logic                  collision_q;

    always_comb begin
        wr_merged   = DATA_WIDTH'(be_merge(word_max_t'(mem_q[wr_addr]), word_max_t'(wr_data),
                                           be_max_t'(wr_be)));
        collision_d = rd_en && wr_en && (rd_addr == wr_addr);
        // wr_merged is built from the old word at wr_addr, which is rd_addr on a collision.
        if (RDW_MODE == RDW_WRITE_FIRST && collision_d) begin
            rd_word = wr_merged;
        end else begin
            rd_word = mem_q[rd_addr];
        end
    end

    // Reset only blocks writes; the array keeps its contents across reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
        end else if (wr_en) begin
            mem_q[wr_addr] <= wr_merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collision_q <= 1'b0;
        end else begin
            collision_q <= collision_d;
        end
    end

    sim_ram_rd_pipe #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (RD_LATENCY)
    ) u_rd_pipe (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (rd_en),
        .data_i  (rd_word),
        .valid_o (rd_valid),
        .data_o  (rd_data)
    );

    assign collision = collision_q;

endmodule

// File: tb/tb_sim_ram_pipe.sv
// Four RAM instances (latency 1/1/3/4, mixed RDW policy) share one stimulus stream;
// an edge-indexed request log predicts every output, plus hand-computed spot values.
module tb_sim_ram_pipe;
    import sim_ram_pkg::*;

    localparam int NI = 4;
    localparam int NE = 256;
    localparam int LAT [NI] = '{1, 1, 3, 4};
    localparam bit WF  [NI] = '{1'b0, 1'b1, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rd_en, wr_en;
    logic [5:0]  rd_addr, wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  wr_be;

    logic [NI-1:0]       rdv, col;
    logic [NI-1:0][31:0] rdd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sim_ram_pipe #(.DATA_SIZE(4), .ADDR_WIDTH(6), .RD_LATENCY(1), .RDW_MODE(RDW_READ_FIRST)) u_a (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[0]),
        .rd_valid(rdv[0]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .collision(col[0]));
    sim_ram_pipe #(.DATA_SIZE(4), .ADDR_WIDTH(6), .RD_LATENCY(1), .RDW_MODE(RDW_WRITE_FIRST)) u_b (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[1]),
        .rd_valid(rdv[1]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .collision(col[1]));
    sim_ram_pipe #(.DATA_SIZE(4), .ADDR_WIDTH(6), .RD_LATENCY(3), .RDW_MODE(RDW_READ_FIRST)) u_c (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[2]),
        .rd_valid(rdv[2]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .collision(col[2]));
    sim_ram_pipe #(.DATA_SIZE(4), .ADDR_WIDTH(6), .RD_LATENCY(4), .RDW_MODE(RDW_WRITE_FIRST)) u_d (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdd[3]),
        .rd_valid(rdv[3]), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .collision(col[3]));

    // Model state: memory with per-byte written mask, and a log of what each edge requested.
    logic [31:0] mmem   [64];
    logic [3:0]  mknown [64];
    logic        req_v  [NI][NE];
    logic [31:0] req_d  [NI][NE];
    logic        req_k  [NI][NE];
    logic        col_req [NE];
    int          n = 0;
    int          kill_n = -1;
    logic        rst_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic        coll;
        logic [31:0] d;
        logic        k;
        for (int a = 0; a < 64; a++) mknown[a] = 4'h0;
        for (int e = 0; e < NE; e++) begin
            col_req[e] = 1'b0;
            for (int i = 0; i < NI; i++) begin
                req_v[i][e] = 1'b0;
                req_d[i][e] = '0;
                req_k[i][e] = 1'b0;
            end
        end
        forever begin
            @(posedge clk);
            n++;
            if (n >= NE) begin
                $display("FAIL edge_budget: got %0d edges expected below %0d", n, NE);
                $fatal(1);
            end
            if (rst_n) begin
                coll = rd_en && wr_en && (rd_addr == wr_addr);
                col_req[n] = coll;
                for (int i = 0; i < NI; i++) begin
                    if (rd_en) begin
                        d = mmem[rd_addr];
                        k = (mknown[rd_addr] == 4'hF);
                        if (WF[i] && coll) begin
                            for (int b = 0; b < 4; b++)
                                if (wr_be[b]) d[8*b +: 8] = wr_data[8*b +: 8];
                            k = ((mknown[rd_addr] | wr_be) == 4'hF);
                        end
                        req_v[i][n] = 1'b1;
                        req_d[i][n] = d;
                        req_k[i][n] = k;
                    end
                end
                if (wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wr_be[b]) begin
                            mmem[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
                            mknown[wr_addr][b]      = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge rst_n);
            kill_n   = n;
            rst_seen = 1'b1;
        end
    end

    initial begin
        logic [31:0] exp_last [NI];
        logic        exp_lk   [NI];
        logic        ev;
        logic        ecol;
        int          src;
        for (int i = 0; i < NI; i++) begin
            exp_last[i] = '0;
            exp_lk[i]   = 1'b1;
        end
        forever begin
            @(posedge clk);
            #1;
            if (rst_seen) begin
                rst_seen = 1'b0;
                for (int i = 0; i < NI; i++) begin
                    exp_last[i] = '0;
                    exp_lk[i]   = 1'b1;
                end
            end
            ecol = rst_n && col_req[n];
            for (int i = 0; i < NI; i++) begin
                ev  = 1'b0;
                src = n - LAT[i] + 1;
                if (rst_n && src >= 1 && src > kill_n && req_v[i][src]) begin
                    ev          = 1'b1;
                    exp_last[i] = req_d[i][src];
                    exp_lk[i]   = req_k[i][src];
                end
                chk($sformatf("model_valid[%0d]@%0d", i, n), 32'(rdv[i]), 32'(ev));
                chk($sformatf("model_collision[%0d]@%0d", i, n), 32'(col[i]), 32'(ecol));
                if (exp_lk[i]) chk($sformatf("model_data[%0d]@%0d", i, n), rdd[i], exp_last[i]);
            end
        end
    end

    // Drive on the falling edge, return 1 time unit after the following rising edge.
    task automatic step(input logic r, input logic [5:0] ra, input logic w, input logic [5:0] wa,
                        input logic [31:0] wd, input logic [3:0] be, input logic rn);
        @(negedge clk);
        rst_n   = rn;
        rd_en   = r;
        rd_addr = ra;
        wr_en   = w;
        wr_addr = wa;
        wr_data = wd;
        wr_be   = be;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b0, 6'd0, 1'b1, a, d, be, 1'b1);
    endtask

    task automatic rd(input logic [5:0] a);
        step(1'b1, a, 1'b0, 6'd0, 32'd0, 4'h0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 4'h0, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
        rd_addr = '0; wr_addr = '0; wr_data = '0; wr_be = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", 32'(rdv), 32'h0);
        chk("reset_collision", 32'(col), 32'h0);
        chk("reset_data_a", rdd[0], 32'h0);
        idle();

        wr(6'd5, 32'hDEADBEEF, 4'hF);
        rd(6'd5);
        chk("full_write_valid", 32'(rdv[0]), 32'd1);
        chk("full_write_data", rdd[0], 32'hDEADBEEF);

        wr(6'd5, 32'h11223344, 4'b0101);
        rd(6'd5);
        chk("partial_write_data", rdd[0], 32'hDE22BE44);

        wr(6'd7, 32'h0, 4'hF);
        step(1'b1, 6'd7, 1'b1, 6'd7, 32'hAAAAAAAA, 4'hF, 1'b1);
        chk("collision_read_first", rdd[0], 32'h0);
        chk("collision_write_first", rdd[1], 32'hAAAAAAAA);
        chk("collision_pulse", 32'(col), 32'hF);
        idle();
        chk("collision_one_cycle", 32'(col), 32'h0);

        for (int a = 0; a < 4; a++) wr(6'(a), 32'h5000_0000 | 32'(a), 4'hF);
        for (int j = 0; j < 8; j++) begin
            step(j < 4, 6'(j), 1'b0, 6'd0, 32'd0, 4'h0, 1'b1);
            chk($sformatf("lat3_valid_%0d", j), 32'(rdv[2]), 32'((j >= 2) && (j <= 5)));
            if (j >= 2 && j <= 5) chk($sformatf("lat3_data_%0d", j), rdd[2], 32'h5000_0000 | 32'(j - 2));
        end

        wr(6'd9, 32'h12345678, 4'hF);
        rd(6'd9);
        chk("hold_first_valid", 32'(rdv[0]), 32'd1);
        for (int j = 0; j < 5; j++) begin
            idle();
            chk($sformatf("hold_valid_%0d", j), 32'(rdv[0]), 32'd0);
            chk($sformatf("hold_data_%0d", j), rdd[0], 32'h12345678);
        end

        wr(6'd12, 32'hCAFEF00D, 4'hF);
        rd(6'd12);
        idle();
        step(1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 4'h0, 1'b0);
        chk("midreset_valid", 32'(rdv[3]), 32'd0);
        chk("midreset_data", rdd[3], 32'h0);
        step(1'b1, 6'd12, 1'b1, 6'd12, 32'h0BAD0BAD, 4'hF, 1'b0);
        step(1'b0, 6'd0, 1'b0, 6'd0, 32'd0, 4'h0, 1'b0);
        chk("midreset_late_valid", 32'(rdv[3]), 32'd0);
        chk("midreset_late_data", rdd[3], 32'h0);
        idle();
        chk("post_reset_valid", 32'(rdv[3]), 32'd0);
        rd(6'd12);
        chk("post_reset_lat1", rdd[0], 32'hCAFEF00D);
        idle();
        idle();
        idle();
        chk("post_reset_lat4_valid", 32'(rdv[3]), 32'd1);
        chk("post_reset_lat4_data", rdd[3], 32'hCAFEF00D);
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sim_ram_pipe.md
# sim_ram_pipe

Parametrised simulation RAM: one write port with per-byte write enables and one read port with a configurable-latency read pipeline. The read pipeline carries a valid strobe and a read-during-write policy selected by parameter. It is the behavioural memory model for testbenches and simulation-only tops, and is driven from the C testbench through a thin Verilog top. Memory contents are not synthesised and are not cleared by reset.

## Interface
- DATA_SIZE, 4: data width in bytes; DATA_WIDTH = 8*DATA_SIZE
- ADDR_WIDTH, 6: address width; depth = 2**ADDR_WIDTH words
- RD_LATENCY, 1: cycles from rd_en to rd_valid; legal range 1..4, elaboration error otherwise
- RDW_MODE, RDW_READ_FIRST: same-address read/write collision policy (RDW_READ_FIRST or RDW_WRITE_FIRST)

Clocking and reset are fixed: one clock; reset is asynchronous and active-low.

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_en  in  1  read request this cycle
- rd_addr  in  ADDR_WIDTH  read word address
- rd_data  out  DATA_WIDTH  read data; valid when rd_valid=1
- rd_valid  out  1  rd_data carries the result of the request issued RD_LATENCY cycles earlier
- wr_en  in  1  write request this cycle
- wr_addr  in  ADDR_WIDTH  write word address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  DATA_SIZE  byte enables; bit i gates wr_data[8i+7:8i]
- collision  out  1  registered pulse: a read and a write to the same address were accepted in the same cycle

## Operation
- Write: on a clk edge with wr_en=1 and rst_n=1, update each byte i of mem[wr_addr] where wr_be[i]=1. Other bytes are unchanged. wr_be=0 is a no-op.
- Read: on a clk edge with rd_en=1, sample mem[rd_addr] into pipeline stage 0 with valid=1. rd_en=0 enters valid=0.
- Pipeline: RD_LATENCY stages of {valid, data}, advancing every cycle with no stall or backpressure. rd_valid and rd_data are the last stage.
- rd_data holds its last valid value while rd_valid=0; it is not zeroed between reads.
- Collision (rd_en and wr_en both 1, rd_addr==wr_addr, same cycle):
  - RDW_READ_FIRST: the read returns pre-write contents.
  - RDW_WRITE_FIRST: the read returns a per-byte merge, wr_data where wr_be=1 and old contents elsewhere.
  - In both modes the collision output pulses 1 for one cycle, one cycle later.
- Reset (rst_n=0, asynchronous): all pipeline valids clear, rd_data=0, rd_valid=0, collision=0. Writes are ignored while rst_n=0.
- Memory array contents are untouched by reset. Reads that were in flight when reset asserts are discarded and never produce rd_valid.
- Uninitialised words read X in 4-state simulation. Verilator 2-state behaviour is whatever the simulator gives and is not checked.

## Timing
- Read latency is exactly RD_LATENCY cycles: rd_en at edge N produces rd_valid=1 after edge N+RD_LATENCY-1, observable in cycle N+RD_LATENCY.
- Full throughput: one read and one write per cycle, back-to-back, with no bubbles.
- A write at edge N is visible to a read issued at edge N+1 or later, regardless of RDW_MODE.
- Reset release is synchronous to the next clk edge: the first read is accepted on the first edge with rst_n=1.
- The collision pulse is asserted in the cycle after the colliding edge, independent of RD_LATENCY.

## Structure
- Package sim_ram_pkg holds:
  - typedef enum rdw_mode_e {RDW_READ_FIRST, RDW_WRITE_FIRST}
  - constant MAX_RD_LATENCY=4
  - function be_merge(old, new, be)
- Sub-module sim_ram_rd_pipe: a parametrised valid+data delay line (WIDTH, DEPTH) with asynchronous reset. It is instantiated once for the read path.
- The top holds the array, the write logic, collision detect, and the RDW merge.

## Test plan
- Write mem[5]=0xDEADBEEF with wr_be=4'hF, then read 5 with RD_LATENCY=1 → rd_valid one cycle after the request, rd_data=0xDEADBEEF.
- Partial write: mem[5]=0xDEADBEEF, then write 0x11223344 with wr_be=4'b0101 → read returns 0xDE22BE44.
- Collision on addr 7 (old 0x0, write 0xAAAAAAAA, be=4'hF):
  - READ_FIRST → rd_data=0x0
  - WRITE_FIRST → rd_data=0xAAAAAAAA
  - both modes → collision=1 for one cycle
- RD_LATENCY=3, reads to addresses 0,1,2,3 on consecutive cycles → rd_valid high for 4 consecutive cycles starting 3 cycles after the first request, data returned in order.
- Reset mid-pipeline:
  - RD_LATENCY=4, issue a read, assert rst_n=0 two cycles later → rd_valid stays 0 and rd_data=0.
  - After release, reading the same address returns its pre-reset contents.
- Idle hold: after a valid read of 0x12345678, drive rd_en=0 for 5 cycles → rd_valid=0 and rd_data stays 0x12345678.
